// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and the
// baud divider helper used by both uart_rx and uart_tx.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } rx_state_t;

   function automatic int clks_per_bit(input int freq, input int baud);
      return freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO with an explicit
// occupancy counter; a push while full is accepted only alongside a pop.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   // Empty FIFO presents zero so the head reads as its reset value.
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (do_pop && !do_push)
            count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver into a byte FIFO with data_ready/read_ack handshake.
// Defining UART_RX_PARITY_EN switches to 8E1 and adds the parity_error output.
//
// state     | meaning
// IDLE      | line idle, waiting for rx_s low
// START     | half-bit wait, then confirm the start bit is still low
// DATA      | sample 8 data bits, LSB first, one per bit period
// PARITY    | sample even-parity bit (parity build only)
// STOP      | sample stop bit; push byte or flag framing error
// WAIT_IDLE | stop bit was low; hold until the line returns high
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQUENCY = 27000000,
   parameter int BAUD_RATE       = 115200,
   parameter int FIFO_DEPTH      = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rx,
   input  logic                          read_ack,
   input  logic                          clear_errors,
   output logic                          data_ready,
   output logic [7:0]                    rx_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          framing_error,
`ifdef UART_RX_PARITY_EN
   output logic                          parity_error,
`endif
   output logic                          overrun
);

   localparam int CPB = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
   localparam int CW  = $clog2(CPB);
   localparam logic [CW-1:0] BIT_LOAD  = CW'(CPB - 1);
   localparam logic [CW-1:0] HALF_LOAD = CW'(CPB / 2 - 1);

   logic                 rx_meta;
   logic                 rx_s;
   rx_state_t            state;
   logic [CW-1:0]        cnt;
   logic [2:0]           bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 push_req;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic                 pop;
`ifdef UART_RX_PARITY_EN
   logic                 parity_ok;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // cnt is a down-counter; every sample point is its terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         bit_idx       <= '0;
         shreg         <= '0;
         push_req      <= 1'b0;
         framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_error  <= 1'b0;
         parity_ok     <= 1'b0;
`endif
      end else begin
         push_req      <= 1'b0;
         framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_error  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state <= START;
                  cnt   <= HALF_LOAD;
               end
            end
            START: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (rx_s) begin
                  state <= IDLE;
               end else begin
                  state   <= DATA;
                  cnt     <= BIT_LOAD;
                  bit_idx <= '0;
               end
            end
            DATA: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                  cnt     <= BIT_LOAD;
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  parity_ok    <= ~(^{shreg, rx_s});
                  parity_error <= ^{shreg, rx_s};
                  cnt          <= BIT_LOAD;
                  state        <= STOP;
               end
            end
`endif
            STOP: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                  push_req <= parity_ok;
`else
                  push_req <= 1'b1;
`endif
                  state    <= IDLE;
               end else begin
                  framing_error <= 1'b1;
                  state         <= WAIT_IDLE;
               end
            end
            WAIT_IDLE: begin
               if (rx_s) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_req),
      .din   (shreg),
      .pop   (read_ack),
      .dout  (rx_data),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   assign data_ready = ~fifo_empty;
   assign pop        = read_ack & ~fifo_empty;

   // A push into a full FIFO survives only if a pop frees a slot that cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         overrun <= 1'b0;
      else if (push_req && fifo_full && !pop)
         overrun <= 1'b1;
      else if (clear_errors)
         overrun <= 1'b0;
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx using a queue-based FIFO model; runs the
// fast build (16 clocks per bit). Define UART_RX_PARITY_EN for the 8E1 build.
module tb_uart_rx;

   localparam int CLK_HZ = 27000000;
   localparam int BAUD   = CLK_HZ / 16;
   localparam int CPB    = CLK_HZ / BAUD;
   localparam int DEPTH  = 64;
`ifdef UART_RX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   // Edge (counted from the edge after which the start bit is driven) at which
   // the received byte is written: 2 sync + 1 detect + half bit + remaining bits + 1.
   localparam int PUSH_EDGE = 3 + CPB / 2 + (FRAME_BITS - 1) * CPB + 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       read_ack = 1'b0;
   logic       clear_errors = 1'b0;
   logic       data_ready;
   logic [7:0] rx_data;
   logic [6:0] fifo_count;
   logic       framing_error;
   logic       overrun;
`ifdef UART_RX_PARITY_EN
   logic       parity_error;
`endif

   always #5 clk = ~clk;

   uart_rx #(
      .CLOCK_FREQUENCY (CLK_HZ),
      .BAUD_RATE       (BAUD),
      .FIFO_DEPTH      (DEPTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx            (rx),
      .read_ack      (read_ack),
      .clear_errors  (clear_errors),
      .data_ready    (data_ready),
      .rx_data       (rx_data),
      .fifo_count    (fifo_count),
      .framing_error (framing_error),
`ifdef UART_RX_PARITY_EN
      .parity_error  (parity_error),
`endif
      .overrun       (overrun)
   );

   logic [7:0] q[$];
   bit         m_ovr = 1'b0;
   bit         chk_en = 1'b0;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         fe_pulses = 0;
   int         pe_pulses = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 20)
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("data_ready", 32'(data_ready), 32'(q.size() != 0));
         chk("fifo_count", 32'(fifo_count), 32'(q.size()));
         if (q.size() != 0) chk("rx_data", 32'(rx_data), 32'(q[0]));
         chk("overrun", 32'(overrun), 32'(m_ovr));
         chk("framing_error_idle", 32'(framing_error), 32'd0);
      end
   end

   always @(negedge clk) begin
      if (framing_error) fe_pulses++;
`ifdef UART_RX_PARITY_EN
      if (parity_error) pe_pulses++;
`endif
   end

   task automatic drive_bit(input logic v);
      rx = v;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit bad_par);
      @(posedge clk);
      #1;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit((^b) ^ bad_par);
`endif
      drive_bit(stop_ok);
   endtask

   function automatic void model_push(input logic [7:0] b);
      if (q.size() < DEPTH) q.push_back(b);
      else m_ovr = 1'b1;
   endfunction

   task automatic rx_byte(input logic [7:0] b, input bit stop_ok = 1'b1, input bit bad_par = 1'b0);
      chk_en = 1'b0;
      send_frame(b, stop_ok, bad_par);
      if (stop_ok && !bad_par) model_push(b);
      rx = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
   endtask

   task automatic pop_byte();
      @(posedge clk);
      #1;
      read_ack = 1'b1;
      @(posedge clk);
      #1;
      read_ack = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
   endtask

   // Sends a good frame and strobes read_ack or clear_errors exactly on its push edge.
   task automatic frame_with_strobe(input logic [7:0] b, input bit use_ack);
      chk_en = 1'b0;
      fork
         send_frame(b, 1'b1, 1'b0);
         begin
            @(posedge clk);
            repeat (PUSH_EDGE - 1) @(posedge clk);
            #1;
            if (use_ack) read_ack = 1'b1;
            else clear_errors = 1'b1;
            @(posedge clk);
            #1;
            read_ack = 1'b0;
            clear_errors = 1'b0;
         end
      join
      rx = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] b;
      logic [7:0] head;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_data_ready", 32'(data_ready), 32'd0);
      chk("reset_rx_data", 32'(rx_data), 32'd0);
      chk("reset_fifo_count", 32'(fifo_count), 32'd0);
      chk("reset_framing_error", 32'(framing_error), 32'd0);
      chk("reset_overrun", 32'(overrun), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk_en = 1'b1;
      repeat (4) @(posedge clk);

      // Two bytes, FWFT head, pops, pop on empty
      rx_byte(8'h55);
      rx_byte(8'hA3);
      @(negedge clk);
      chk("t1_ready", 32'(data_ready), 32'd1);
      chk("t1_head", 32'(rx_data), 32'h55);
      chk("t1_count", 32'(fifo_count), 32'd2);
      pop_byte();
      @(negedge clk);
      chk("t1_head2", 32'(rx_data), 32'hA3);
      chk("t1_count2", 32'(fifo_count), 32'd1);
      pop_byte();
      @(negedge clk);
      chk("t1_empty", 32'(data_ready), 32'd0);
      pop_byte();
      @(negedge clk);
      chk("t1_pop_empty_count", 32'(fifo_count), 32'd0);

      // Short low glitch must be rejected as a false start
      @(posedge clk);
      #1;
      rx = 1'b0;
      repeat (CPB / 4) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (2 * CPB) @(posedge clk);
      chk("t2_no_fe", 32'(fe_pulses), 32'd0);
      rx_byte(8'h5A);
      @(negedge clk);
      chk("t2_after_glitch", 32'(rx_data), 32'h5A);
      pop_byte();

      // Framing errors: bad stop bit, then a long break, then a good byte
      rx_byte(8'h3C, 1'b0);
      chk_en = 1'b0;
      send_frame(8'h00, 1'b0, 1'b0);
      repeat (3 * CPB) @(posedge clk);
      #1;
      rx = 1'b1;
      repeat (CPB) @(posedge clk);
      #1;
      chk_en = 1'b1;
      rx_byte(8'h7E);
      @(negedge clk);
      chk("t3_fe_pulses", 32'(fe_pulses), 32'd2);
      chk("t3_head", 32'(rx_data), 32'h7E);
      chk("t3_count", 32'(fifo_count), 32'd1);
      pop_byte();

      // Randomised bytes, pops and idle gaps
      for (int i = 0; i < 24; i++) begin
         b = 8'($urandom);
         rx_byte(b);
         repeat ($urandom_range(0, CPB)) @(posedge clk);
         #1;
         if ($urandom_range(0, 2) == 0) pop_byte();
      end
      while (q.size() != 0) pop_byte();

      // Overflow: 65 bytes, clear_errors coincident with the dropping push
      for (int i = 0; i < 64; i++) rx_byte(8'(i));
      frame_with_strobe(8'h40, 1'b0);
      m_ovr = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      @(negedge clk);
      chk("t4_count", 32'(fifo_count), 32'd64);
      chk("t4_overrun", 32'(overrun), 32'd1);
      @(posedge clk);
      #1;
      clear_errors = 1'b1;
      @(posedge clk);
      #1;
      clear_errors = 1'b0;
      m_ovr = 1'b0;
      @(negedge clk);
      chk("t4_cleared", 32'(overrun), 32'd0);

      // Full FIFO with pop on the exact push edge
      frame_with_strobe(8'h41, 1'b1);
      void'(q.pop_front());
      q.push_back(8'h41);
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      @(negedge clk);
      chk("t5_overrun", 32'(overrun), 32'd0);
      chk("t5_count", 32'(fifo_count), 32'd64);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         head = rx_data;
         chk("t5_drain", 32'(head), (i == 63) ? 32'h41 : 32'(i + 1));
         pop_byte();
      end

      // Reset during data bit 4, then a fresh byte
      rx_byte(8'h11);
      chk_en = 1'b0;
      fork
         send_frame(8'hF0, 1'b1, 1'b0);
         begin
            @(posedge clk);
            repeat (5 * CPB + CPB / 2) @(posedge clk);
            #3;
            rst_n = 1'b0;
            q.delete();
            m_ovr = 1'b0;
            chk_en = 1'b1;
            @(negedge clk);
            chk("t6_rst_ready", 32'(data_ready), 32'd0);
            chk("t6_rst_rx_data", 32'(rx_data), 32'd0);
            chk("t6_rst_count", 32'(fifo_count), 32'd0);
            repeat (CPB) @(posedge clk);
            #2;
            rst_n = 1'b1;
         end
      join
      rx = 1'b1;
      repeat (CPB) @(posedge clk);
      #1;
`ifdef UART_RX_PARITY_EN
      rx_byte(8'h81, 1'b1, 1'b1);
      @(negedge clk);
      chk("t6_parity_pulse", 32'(pe_pulses), 32'd1);
      chk("t6_parity_no_push", 32'(data_ready), 32'd0);
`else
      rx_byte(8'h81);
      @(negedge clk);
      chk("t6_head", 32'(rx_data), 32'h81);
      chk("t6_count", 32'(fifo_count), 32'd1);
`endif
      chk("final_fe_pulses", 32'(fe_pulses), 32'd2);
      repeat (4) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
